// File: rtl/shift_mult_seq.sv
// Sequential shift-add multiplier: one multiplier bit per clock, full-width exact product,
// per-operation signed/unsigned mode and optional early termination. State updates on negedge clk.
module shift_mult_seq #(
    parameter int A_WIDTH    = 16,
    parameter int B_WIDTH    = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic                       clk,
    input  logic                       mult_rst,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic                       busy,
    output logic                       done,
    output logic [A_WIDTH+B_WIDTH-1:0] y
);

    localparam int W  = A_WIDTH + B_WIDTH;
    localparam int CW = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(B_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       m_q, m_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       y_q, y_d;
    logic [B_WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [A_WIDTH-1:0] a_mag;
    logic [B_WIDTH-1:0] b_mag;
    logic [B_WIDTH-1:0] r_shift;

    always_comb begin
        // Magnitudes of the most-negative values still fit unsigned in their own width.
        a_mag   = (signed_mode && a[A_WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag   = (signed_mode && b[B_WIDTH-1]) ? (~b + 1'b1) : b;
        r_shift = r_q >> 1;

        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        y_d     = y_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            IDLE, DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    m_d     = W'(a_mag);
                    r_d     = b_mag;
                    neg_d   = signed_mode & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (EARLY_EXIT != 0 && b_mag == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (r_q[0]) acc_d = acc_q + m_q;
                m_d   = m_q << 1;
                r_d   = r_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST || (EARLY_EXIT != 0 && r_shift == '0))
                    state_d = FIN;
            end
            FIN: begin
                y_d     = neg_q ? (~acc_q + 1'b1) : acc_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (mult_rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

endmodule

// File: tb/tb_shift_mult_seq.sv
// Self-checking bench for shift_mult_seq: four configurations (16x8 / 8x12, with and without
// early exit) checked against directed vectors, handshake/reset sequences and a random model.
module tb_shift_mult_seq;

    logic        clk;
    logic        rst;
    logic        st [4];
    logic        sm [4];
    logic [15:0] av [4];
    logic [11:0] bv [4];
    wire         bz [4];
    wire         dn [4];
    wire  [27:0] yv [4];
    logic [23:0] y0, y1;
    logic [19:0] y2, y3;

    assign yv[0] = {4'b0, y0};
    assign yv[1] = {4'b0, y1};
    assign yv[2] = {8'b0, y2};
    assign yv[3] = {8'b0, y3};

    shift_mult_seq #(.A_WIDTH(16), .B_WIDTH(8), .EARLY_EXIT(0)) u0 (
        .clk(clk), .mult_rst(rst), .start(st[0]), .signed_mode(sm[0]),
        .a(av[0]), .b(bv[0][7:0]), .busy(bz[0]), .done(dn[0]), .y(y0));
    shift_mult_seq #(.A_WIDTH(16), .B_WIDTH(8), .EARLY_EXIT(1)) u1 (
        .clk(clk), .mult_rst(rst), .start(st[1]), .signed_mode(sm[1]),
        .a(av[1]), .b(bv[1][7:0]), .busy(bz[1]), .done(dn[1]), .y(y1));
    shift_mult_seq #(.A_WIDTH(8), .B_WIDTH(12), .EARLY_EXIT(0)) u2 (
        .clk(clk), .mult_rst(rst), .start(st[2]), .signed_mode(sm[2]),
        .a(av[2][7:0]), .b(bv[2]), .busy(bz[2]), .done(dn[2]), .y(y2));
    shift_mult_seq #(.A_WIDTH(8), .B_WIDTH(12), .EARLY_EXIT(1)) u3 (
        .clk(clk), .mult_rst(rst), .start(st[3]), .signed_mode(sm[3]),
        .a(av[3][7:0]), .b(bv[3]), .busy(bz[3]), .done(dn[3]), .y(y3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          d;
        bit          s;
        logic [15:0] a;
        logic [11:0] b;
        logic [27:0] y;
        int          lat;
    } vec_t;

    vec_t tbl [11];

    function automatic int awid(input int d); return (d < 2) ? 16 : 8;  endfunction
    function automatic int bwid(input int d); return (d < 2) ? 8  : 12; endfunction
    function automatic bit early(input int d); return (d == 1 || d == 3); endfunction

    // Reference: plain integer multiply of the interpreted operands, wrapped to the product width.
    function automatic logic [27:0] ref_prod(input int d, input bit s, input longint ai, input longint bi);
        int     aw = awid(d);
        int     bw = bwid(d);
        longint sa = ai;
        longint sb = bi;
        longint p;
        if (s && ai[aw-1]) sa = ai - (longint'(1) << aw);
        if (s && bi[bw-1]) sb = bi - (longint'(1) << bw);
        p = (sa * sb) & ((longint'(1) << (aw + bw)) - 1);
        return 28'(p);
    endfunction

    // Edges from the accepting edge through the edge that raises done, inclusive.
    function automatic int ref_lat(input int d, input bit s, input longint bi);
        int     bw  = bwid(d);
        longint mag = bi;
        int     hi  = 0;
        if (!early(d)) return bw + 2;
        if (s && bi[bw-1]) mag = (longint'(1) << bw) - bi;
        for (int i = 0; i < bw; i++) if (mag[i]) hi = i + 1;
        return hi + 2;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_op(input int d, input bit s, input logic [15:0] a_in, input logic [11:0] b_in,
                         output logic [27:0] y_out, output int lat, output int bcnt);
        @(posedge clk);
        st[d] = 1'b1; sm[d] = s; av[d] = a_in; bv[d] = b_in;
        @(negedge clk); #1;
        st[d] = 1'b0; sm[d] = ~s; av[d] = 16'($urandom); bv[d] = 12'($urandom);
        lat  = 1;
        bcnt = bz[d] ? 1 : 0;
        while (!dn[d] && lat < 64) begin
            @(negedge clk); #1;
            lat++;
            if (bz[d]) bcnt++;
        end
        y_out = yv[d];
        @(negedge clk); #1;
        check("done_one_cycle", 64'(dn[d]), 64'd0);
        check("y_hold", 64'(yv[d]), 64'(y_out));
    endtask

    task automatic run_rand(input int d, input int n);
        logic [27:0] yo;
        int          lat, bc;
        bit          s;
        logic [15:0] ai;
        logic [11:0] bi;
        for (int i = 0; i < n; i++) begin
            s  = 1'($urandom);
            ai = (d < 2) ? 16'($urandom) : {8'b0, 8'($urandom)};
            bi = 12'($urandom);
            if ($urandom_range(0, 3) == 0) bi = bi & 12'h00F;
            if (d < 2) bi[11:8] = 4'b0;
            do_op(d, s, ai, bi, yo, lat, bc);
            check($sformatf("rand_y d%0d s%0d a%0h b%0h", d, s, ai, bi), 64'(yo), 64'(ref_prod(d, s, ai, bi)));
            check($sformatf("rand_lat d%0d b%0h", d, bi), 64'(lat), 64'(ref_lat(d, s, bi)));
        end
    endtask

    logic [15:0] ha [50];
    logic [7:0]  hb [50];
    bit          hs [50];

    initial begin
        logic [27:0] yo;
        int          lat, bc, next_done, pulses;

        tbl[0]  = '{0, 1'b0, 16'hFFFF, 12'h0FF, 28'hFEFF01, 10};
        tbl[1]  = '{0, 1'b1, 16'h8000, 12'h080, 28'h400000, 10};
        tbl[2]  = '{0, 1'b1, 16'h0003, 12'h0FB, 28'hFFFFF1, 10};
        tbl[3]  = '{1, 1'b0, 16'd1234, 12'h003, 28'd3702,   4};
        tbl[4]  = '{1, 1'b0, 16'd1234, 12'h000, 28'd0,      2};
        tbl[5]  = '{1, 1'b1, 16'h0003, 12'h0FB, 28'hFFFFF1, 5};
        tbl[6]  = '{1, 1'b1, 16'h8000, 12'h080, 28'h400000, 10};
        tbl[7]  = '{1, 1'b1, 16'hFFFF, 12'h001, 28'hFFFFFF, 3};
        tbl[8]  = '{2, 1'b0, 16'h00FF, 12'hFFF, 28'hFEF01,  14};
        tbl[9]  = '{2, 1'b1, 16'h0080, 12'h800, 28'h40000,  14};
        tbl[10] = '{3, 1'b1, 16'h007F, 12'hFFF, 28'hFFF81,  3};

        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            st[d] = 1'b0; sm[d] = 1'b0; av[d] = '0; bv[d] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset_y d%0d", d), 64'(yv[d]), 64'd0);
            check($sformatf("reset_busy d%0d", d), 64'(bz[d]), 64'd0);
            check($sformatf("reset_done d%0d", d), 64'(dn[d]), 64'd0);
        end
        @(posedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].d, tbl[i].s, tbl[i].a, tbl[i].b, yo, lat, bc);
            check($sformatf("vec%0d_y", i), 64'(yo), 64'(tbl[i].y));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
            check($sformatf("vec%0d_busy", i), 64'(bc), 64'(tbl[i].lat - 1));
        end

        // start held high: accepts every B_WIDTH+2 edges, each result from its own accepting edge
        next_done = 9;
        pulses    = 0;
        @(posedge clk);
        for (int n = 0; n < 50; n++) begin
            ha[n] = 16'($urandom); hb[n] = 8'($urandom); hs[n] = 1'($urandom);
            st[0] = 1'b1; av[0] = ha[n]; bv[0] = {4'b0, hb[n]}; sm[0] = hs[n];
            @(negedge clk); #1;
            if (dn[0]) begin
                pulses++;
                check("hs_spacing", 64'(n), 64'(next_done));
                if (n >= 9)
                    check("hs_y", 64'(yv[0]), 64'(ref_prod(0, hs[n-9], 64'(ha[n-9]), 64'(hb[n-9]))));
                next_done += 10;
            end
            @(posedge clk);
        end
        st[0] = 1'b0;
        check("hs_pulses", 64'(pulses), 64'd5);
        @(negedge clk); #1;

        // reset mid-operation
        @(posedge clk);
        st[0] = 1'b1; sm[0] = 1'b0; av[0] = 16'h1234; bv[0] = 12'h056;
        @(negedge clk); #1;
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_busy", 64'(bz[0]), 64'd0);
        check("midrst_done", 64'(dn[0]), 64'd0);
        check("midrst_y", 64'(yv[0]), 64'd0);
        @(posedge clk);
        rst = 1'b0;
        do_op(0, 1'b0, 16'h1234, 12'h056, yo, lat, bc);
        check("postrst_y", 64'(yo), 64'(28'h1234 * 28'h56));
        check("postrst_lat", 64'(lat), 64'd10);

        run_rand(2, 1000);
        run_rand(3, 300);
        run_rand(0, 200);
        run_rand(1, 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_mult_seq.md
Name: shift_mult_seq

Overview:
- Parametrised sequential shift-add multiplier; successor to the fixed 16-bit, B_WIDTH-step multiplier core.
- Adds a start/busy/done handshake, a full-width product, a per-operation signed/unsigned mode, and optional early termination.
- Sits beside the datapath as a low-area multiplier that processes one multiplier bit per clock.

Parameters:
A_WIDTH, 16, multiplicand width (>=2)
B_WIDTH, 8, multiplier width (>=2); sets the maximum number of iteration cycles
EARLY_EXIT, 0, 1 = leave RUN as soon as the remaining multiplier bits are all zero; 0 = fixed latency

Ports:
clk  input  1  single clock; all registers update on the falling edge of clk
mult_rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; accepted only when busy=0
signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned; sampled with start
a  input  A_WIDTH  multiplicand, sampled with start
b  input  B_WIDTH  multiplier, sampled with start
busy  output  1  high while an operation is in progress (RUN and FIN states)
done  output  1  one-cycle pulse; y is valid from this cycle onward
y  output  A_WIDTH+B_WIDTH  product register; holds its value until the next done or reset

Behaviour:
- Reset: mult_rst=1 at a clk edge forces state=IDLE, busy=0, done=0, y=0, and clears all internal registers. This holds in every state, including mid-operation; the aborted result is lost. mult_rst has priority over start.
- State IDLE (busy=0, done=0):
  - start=1 at edge E0 latches |a| into the zero-extended shifter m (A_WIDTH+B_WIDTH bits) and |b| into r (B_WIDTH bits).
  - It also sets neg = signed_mode & (a_msb ^ b_msb), clears the accumulator acc and the step counter cnt, and goes to RUN.
  - When signed_mode=0, the magnitudes are the raw inputs and neg=0.
  - The signed magnitude of the most-negative value (e.g. -128 for B_WIDTH=8) is 2^(W-1) and fits unsigned in W bits.
  - With EARLY_EXIT=1 and |b|=0, E0 goes directly to FIN.
- State RUN (busy=1), at each edge:
  - If r[0]=1, acc <= acc + m (modulo 2^(A_WIDTH+B_WIDTH)).
  - m <= m<<1; r <= r>>1; cnt <= cnt+1.
  - Go to FIN when cnt = B_WIDTH-1, or (EARLY_EXIT=1 and (r>>1)==0); otherwise stay in RUN.
- State FIN (busy=1): at the next edge, y <= neg ? -acc : acc (two's complement, full width), done <= 1, and the state goes to DONE.
- State DONE (busy=0, done=1 for exactly one cycle):
  - At the next edge done returns to 0.
  - start=1 in DONE is accepted exactly as in IDLE, so back-to-back operations have no idle gap.
  - Otherwise the state goes to IDLE.
- start while busy=1 is ignored; it is not queued. a, b and signed_mode may change freely after the accepting edge.
- Latency with EARLY_EXIT=0: the accepting edge is E0, RUN occupies edges E1..E_B_WIDTH, FIN writes y at E_(B_WIDTH+1), and done is high during the following cycle. Throughput is one result per B_WIDTH+2 cycles.
- Latency with EARLY_EXIT=1: the number of RUN edges equals the index of the highest set bit of |b| plus 1, with a minimum of 0 RUN edges when |b|=0.
- Result width: y is always exact; for signed operands the full signed range fits, e.g. (-2^15)*(-2^7) = 2^22 < 2^23.
- y is not cleared by start; it changes only at FIN or on reset.

Test Plan:
- Defaults, unsigned: a=0xFFFF, b=0xFF, signed_mode=0 -> done exactly 10 cycles after the start edge; y=0xFEFF01; busy high for 9 cycles.
- Signed corners: a=0x8000 (-32768), b=0x80 (-128), signed_mode=1 -> y=0x400000. Then a=0x0003, b=0xFB (-5) -> y=0xFFFFF1 (-15).
- Early exit: EARLY_EXIT=1, a=1234, b=0x03 -> 2 RUN cycles, done 4 cycles after start, y=3702. Then b=0 -> done 2 cycles after start, y=0.
- Handshake: start held high continuously with changing operands -> ops accepted only at IDLE/DONE; consecutive done pulses exactly B_WIDTH+2 cycles apart; each y matches the operands sampled at its accepting edge.
- Mid-op reset: assert mult_rst 4 cycles into an operation -> next cycle busy=0, done=0, y=0; a new start afterwards produces the correct product.
- Non-default widths: A_WIDTH=8, B_WIDTH=12, random signed and unsigned pairs (>=1000) -> y equals the reference product for every operation; done latency is 14 with EARLY_EXIT=0.
